// File: rtl/serving_ram_wb_bridge.sv
// Wishbone (32-bit) to byte-wide RAM bridge: each request is split into four little-endian byte accesses.
// Optional macro SERVING_RAM_BRIDGE_LANESKIP_EN makes writes visit only the selected byte lanes.
module serving_ram_wb_bridge #(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [aw-1:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic [aw-1:0] o_ram_waddr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_wen,
    output logic [aw-1:0] o_ram_raddr,
    output logic          o_ram_ren,
    input  logic [7:0]    i_ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDLAST} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic        r_ack, w_ack_nxt;
    logic [31:0] r_rdt;
    logic        w_cap;
    logic [1:0]  w_cap_lane;
    logic [1:0]  w_first_lane;
    logic [1:0]  w_next_lane;
    logic        w_more;
    logic        w_unused;

    assign w_unused = ^i_wb_adr[1:0];

`ifdef SERVING_RAM_BRIDGE_LANESKIP_EN
    // Lowest selected lane overall, and lowest selected lane above the current one.
    always_comb begin
        w_first_lane = 2'd0;
        w_next_lane  = 2'd0;
        w_more       = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (i_wb_sel[k]) begin
                w_first_lane = 2'(k);
            end
            if (i_wb_sel[k] && (k > int'(r_cnt))) begin
                w_next_lane = 2'(k);
                w_more      = 1'b1;
            end
        end
    end
`else
    assign w_first_lane = 2'd0;
    assign w_next_lane  = r_cnt + 2'd1;
    assign w_more       = (r_cnt != 2'd3);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_ack   <= 1'b0;
            r_rdt   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            if (w_cap) begin
                r_rdt[{w_cap_lane, 3'b000} +: 8] <= i_ram_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = 1'b0;
        w_cap       = 1'b0;
        w_cap_lane  = r_cnt - 2'd1;
        o_ram_wen   = 1'b0;
        o_ram_ren   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The ack cycle itself never starts a new request.
                if (i_wb_stb && !r_ack) begin
                    w_cnt_nxt   = i_wb_we ? w_first_lane : 2'd0;
                    w_state_nxt = i_wb_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                o_ram_wen = i_wb_sel[r_cnt];
                if (w_more) begin
                    w_cnt_nxt = w_next_lane;
                end else begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = 1'b1;
                end
            end
            S_RD: begin
                o_ram_ren = 1'b1;
                w_cap     = (r_cnt != 2'd0);
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_RDLAST;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_RDLAST: begin
                w_cap       = 1'b1;
                w_cap_lane  = 2'd3;
                w_cnt_nxt   = 2'd0;
                w_state_nxt = S_IDLE;
                w_ack_nxt   = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_ram_waddr = {i_wb_adr[aw-1:2], r_cnt};
    assign o_ram_raddr = {i_wb_adr[aw-1:2], r_cnt};
    assign o_ram_wdata = i_wb_dat[{r_cnt, 3'b000} +: 8];
    assign o_wb_ack    = r_ack;
    assign o_wb_rdt    = r_rdt;

endmodule

// File: tb/tb_serving_ram_wb_bridge.sv
// Self-checking bench for serving_ram_wb_bridge: directed vector table, reset/back-to-back sequences,
// and random transactions checked against a byte-array reference of the RAM.
module tb_serving_ram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we  = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [7:0]  ram_waddr, ram_raddr, ram_wdata;
    logic        ram_wen, ram_ren;
    logic [7:0]  ram_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] m_rdt = '0;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];

    always #5 clk = ~clk;

    serving_ram_wb_bridge #(.depth(256)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_stb(wb_stb),
        .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
        .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata), .o_ram_wen(ram_wen),
        .o_ram_raddr(ram_raddr), .o_ram_ren(ram_ren), .i_ram_rdata(ram_rdata)
    );

    // Byte RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    // Record every RAM access the bridge presents, mid-cycle.
    always @(negedge clk) begin
        if (ram_wen) wq.push_back({ram_waddr, ram_wdata});
        if (ram_ren) rq.push_back(ram_raddr);
    end

    function automatic logic [7:0] pattern(int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, input bit keep_stb, output logic [31:0] rdt);
        logic [7:0]  base;
        logic [15:0] ew[$];
        logic [7:0]  er[$];
        int exp_lat, n, pop, bad;
        base = {adr[7:2], 2'b00};
        pop = 0;
        for (int k = 0; k < 4; k++) if (sel[k]) pop++;
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (sel[k]) ew.push_back({base | 8'(k), dat[8*k +: 8]});
`ifdef SERVING_RAM_BRIDGE_LANESKIP_EN
            exp_lat = (pop == 0) ? 1 : pop;
`else
            exp_lat = 4;
`endif
        end else begin
            for (int k = 0; k < 4; k++) er.push_back(base | 8'(k));
            exp_lat = 5;
            m_rdt = {ref_mem[base | 8'd3], ref_mem[base | 8'd2], ref_mem[base | 8'd1], ref_mem[base]};
        end
        wq.delete();
        rq.delete();
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_stb = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 20);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("rdt", wb_rdt, m_rdt);
        rdt = wb_rdt;
        if (!keep_stb) wb_stb = 1'b0;
        chk("wr_count", 32'(wq.size()), 32'(ew.size()));
        chk("rd_count", 32'(rq.size()), 32'(er.size()));
        bad = 0;
        for (int i = 0; i < wq.size() && i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
        for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
        chk("access_seq", 32'(bad), 32'd0);
        if (we) for (int k = 0; k < 4; k++) if (sel[k]) ref_mem[base | 8'(k)] = dat[8*k +: 8];
        @(posedge clk); #1;
        chk("ack_width", {31'd0, wb_ack}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] exp_rdt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] got;
        vecs[0] = '{8'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 32'h0};
        vecs[1] = '{8'h10, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{8'h12, 32'h00005500, 4'b0010, 1'b1, 32'h0};
        vecs[3] = '{8'h10, 32'h0,        4'b1111, 1'b0, 32'hDEAD55EF};
        vecs[4] = '{8'hFC, 32'h0,        4'b0101, 1'b0, 32'hE0BB9671};
        vecs[5] = '{8'h20, 32'hA1B2C3D4, 4'b1001, 1'b1, 32'h0};
        vecs[6] = '{8'h20, 32'h0,        4'b1111, 1'b0, 32'hA1EFCAD4};
        for (int i = 0; i < 256; i++) begin
            mem[i]     = pattern(i);
            ref_mem[i] = pattern(i);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_rdt", wb_rdt, 32'd0);
        chk("rst_wen", {31'd0, ram_wen}, 32'd0);
        chk("rst_ren", {31'd0, ram_ren}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, 1'b0, got);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdt", i), got, vecs[i].exp_rdt);
        end

        // Reset two edges into a read: ren drops, rdt clears, no ack, no further access.
        wq.delete(); rq.delete();
        wb_adr = 8'h40; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ren", {31'd0, ram_ren}, 32'd0);
        chk("abort_rdt", wb_rdt, 32'd0);
        wb_stb = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_noack", {31'd0, wb_ack}, 32'd0);
        end
        chk("abort_reads", 32'(rq.size()), 32'd2);
        rst = 1'b0;
        m_rdt = 32'd0;
        @(posedge clk); #1;
        do_txn(8'h40, 32'h0, 4'hF, 1'b0, 1'b0, got);
        chk("post_abort_rdt", got, {pattern(67), pattern(66), pattern(65), pattern(64)});

        // stb held through ack: the next edge after ack falls accepts the repeat.
        do_txn(8'h80, 32'h11223344, 4'b1001, 1'b1, 1'b1, got);
        do_txn(8'h80, 32'h11223344, 4'b1001, 1'b1, 1'b0, got);
        do_txn(8'h84, 32'h55667788, 4'b1111, 1'b1, 1'b1, got);
        do_txn(8'h84, 32'h55667788, 4'b1111, 1'b1, 1'b0, got);
        do_txn(8'h84, 32'h0, 4'b0000, 1'b0, 1'b0, got);
        chk("b2b_rdt", got, 32'h55667788);

        for (int i = 0; i < 40; i++) begin
            do_txn(8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'b0, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
